// File: rtl/io_delay_sweep_ctrl_pkg.sv
// Shared constants for io_delay_sweep_ctrl: tap/channel geometry, FSM encodings
// and the per-channel slice index helper used for dicnt/docnt packing.
package io_delay_sweep_ctrl_pkg;

  localparam int TAP_W  = 5;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_RDY = 3'd1;
  localparam logic [2:0] S_LOAD     = 3'd2;
  localparam logic [2:0] S_SETTLE   = 3'd3;
  localparam logic [2:0] S_CHECK    = 3'd4;
  localparam logic [2:0] S_DWELL    = 3'd5;
  localparam logic [2:0] S_FINISH   = 3'd6;

  // Low bit of channel ch's tap field in the packed dicnt/docnt buses.
  function automatic int ch_lo(input logic [1:0] ch);
    return TAP_W * int'(ch);
  endfunction

endpackage

// File: rtl/io_delay_sweep_ctrl_counter.sv
// Free-running cycle counter with synchronous clear, used for settle/dwell timing.
module io_delay_sweep_ctrl_counter #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_clr,
  input  logic                   i_en,
  output logic [COUNT_WIDTH-1:0] o_count
);

  logic [COUNT_WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/io_delay_sweep_ctrl.sv
// IO delay tap load/sweep controller for four delay channels.
// Define IO_DELAY_SWEEP_VERIFY_EN to enable the settle + readback-compare step.
module io_delay_sweep_ctrl
  import io_delay_sweep_ctrl_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES  = 1024,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    dly_rdy,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_ch,
  input  logic                    cmd_sweep,
  input  logic [TAP_W-1:0]        cmd_tap,
  input  logic                    abort,
  output logic [NUM_CH-1:0]       ldcnt,
  output logic [NUM_CH*TAP_W-1:0] dicnt,
  input  logic [NUM_CH*TAP_W-1:0] docnt,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [TAP_W-1:0]        cur_tap
);

  localparam logic [CNT_W-1:0] DWELL_LAST  = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [2:0]              r_state;
  logic [2:0]              w_next;
  logic [1:0]              r_ch;
  logic                    r_sweep;
  logic [TAP_W-1:0]        r_end;
  logic [TAP_W-1:0]        r_tap;
  logic [TAP_W-1:0]        w_load_tap;
  logic [NUM_CH*TAP_W-1:0] r_dicnt;
  logic                    w_accept;
  logic                    w_clr;
  logic                    w_en;
  logic [CNT_W-1:0]        w_cnt;
  logic [CNT_W-1:0]        w_cnt_last;
  logic                    w_cnt_hit;

  assign cmd_ready  = (r_state == S_IDLE);
  assign w_accept   = cmd_valid & cmd_ready & ~abort;
  assign w_cnt_last = (r_state == S_SETTLE) ? SETTLE_LAST : DWELL_LAST;
  assign w_cnt_hit  = (w_cnt == w_cnt_last);
  assign w_load_tap = (r_state == S_DWELL) ? r_tap + 5'd1 : r_tap;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_accept) w_next = S_WAIT_RDY;
      S_WAIT_RDY: if (dly_rdy) w_next = S_LOAD;
`ifdef IO_DELAY_SWEEP_VERIFY_EN
      S_LOAD:     w_next = S_SETTLE;
`else
      S_LOAD:     w_next = r_sweep ? S_DWELL : S_FINISH;
`endif
      S_SETTLE:   if (w_cnt_hit) w_next = S_CHECK;
      S_CHECK:    w_next = r_sweep ? S_DWELL : S_FINISH;
      S_DWELL:    if (w_cnt_hit) w_next = (r_tap == r_end) ? S_FINISH : S_LOAD;
      S_FINISH:   w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
    if (abort) w_next = S_IDLE;
  end

  // Counter restarts from 0 on every state change, so w_cnt is cycles-in-state.
  assign w_clr = (w_next != r_state);
  assign w_en  = (r_state == S_SETTLE) || (r_state == S_DWELL);

  io_delay_sweep_ctrl_counter #(
    .COUNT_WIDTH(CNT_W)
  ) u_counter (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .i_en   (w_en),
    .o_count(w_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ch    <= '0;
      r_sweep <= 1'b0;
      r_end   <= '0;
      r_tap   <= '0;
      r_dicnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_ch    <= cmd_ch;
        r_sweep <= cmd_sweep;
        r_end   <= cmd_tap;
        r_tap   <= cmd_sweep ? '0 : cmd_tap;
      end else if ((r_state == S_DWELL) && (w_next == S_LOAD)) begin
        r_tap <= w_load_tap;
      end
      // dicnt is written on entry to LOAD so it is stable alongside the strobe.
      if (w_next == S_LOAD) begin
        r_dicnt[ch_lo(r_ch) +: TAP_W] <= w_load_tap;
      end
    end
  end

`ifdef IO_DELAY_SWEEP_VERIFY_EN
  logic r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= 1'b0;
    end else if ((r_state == S_CHECK) && (docnt[ch_lo(r_ch) +: TAP_W] != r_tap)) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  logic w_unused_docnt;
  assign w_unused_docnt = ^docnt;
  assign err = 1'b0;
`endif

  assign ldcnt   = (r_state == S_LOAD) ? (4'b0001 << r_ch) : '0;
  assign dicnt   = r_dicnt;
  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_FINISH);
  assign cur_tap = r_tap;

endmodule

// File: tb/tb_io_delay_sweep_ctrl.sv
// Directed self-checking bench for io_delay_sweep_ctrl (DWELL_CYCLES=8, SETTLE_CYCLES=4).
module tb_io_delay_sweep_ctrl;

  localparam int DW = 8;
  localparam int SC = 4;
`ifdef IO_DELAY_SWEEP_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif
  localparam int CHK_LAT = VERIFY ? SC + 1 : 0;
  localparam int SPACING = 1 + CHK_LAT + DW;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dly_rdy = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_ch = '0;
  logic        cmd_sweep = 1'b0;
  logic [4:0]  cmd_tap = '0;
  logic        abort = 1'b0;
  logic [3:0]  ldcnt;
  logic [19:0] dicnt;
  logic [19:0] docnt;
  logic        busy, done, err;
  logic [4:0]  cur_tap;
  logic [19:0] stuck_mask = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int ld_total = 0;
  int done_total = 0;
  int err_cycles = 0;

  assign docnt = dicnt & ~stuck_mask;

  io_delay_sweep_ctrl #(
    .DWELL_CYCLES (DW),
    .SETTLE_CYCLES(SC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .dly_rdy  (dly_rdy),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_ch   (cmd_ch),
    .cmd_sweep(cmd_sweep),
    .cmd_tap  (cmd_tap),
    .abort    (abort),
    .ldcnt    (ldcnt),
    .dicnt    (dicnt),
    .docnt    (docnt),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .cur_tap  (cur_tap)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ldcnt != 4'b0) ld_total++;
    if (done) done_total++;
    if (err) err_cycles++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] ch, input logic sw, input logic [4:0] tap);
    cmd_ch    = ch;
    cmd_sweep = sw;
    cmd_tap   = tap;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_ld(input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (ldcnt == 4'b0 && n < limit);
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < limit);
  endtask

  initial begin
    int n;
    int ld0, dn0, er0;
    logic [4:0] s;

    // Reset values
    #2;
    chk("rst_ldcnt", ldcnt, 0);
    chk("rst_dicnt", dicnt, 0);
    chk("rst_cur_tap", cur_tap, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("rst_cmd_ready", cmd_ready, 1);

    // Single load ch2 tap 17
    dly_rdy = 1'b1;
    ld0 = ld_total; dn0 = done_total;
    send(2'd2, 1'b0, 5'd17);
    chk("s1_busy", busy, 1);
    chk("s1_cmd_ready", cmd_ready, 0);
    wait_ld(10, n);
    chk("s1_ld_lat", n, 1);
    chk("s1_ldcnt", ldcnt, 4'b0100);
    s = dicnt[14:10];
    chk("s1_dicnt", s, 17);
    chk("s1_cur_tap", cur_tap, 17);
    wait_done(30, n);
    chk("s1_done_lat", n, CHK_LAT + 1);
    chk("s1_err", err, 0);
    tick();
    chk("s1_done_pulse", done, 0);
    chk("s1_idle", busy, 0);
    chk("s1_ld_count", ld_total - ld0, 1);
    chk("s1_done_count", done_total - dn0, 1);

    // Sweep ch0 end tap 3
    ld0 = ld_total; dn0 = done_total;
    send(2'd0, 1'b1, 5'd3);
    for (int p = 0; p < 4; p++) begin
      wait_ld(40, n);
      chk("sw_gap", n, (p == 0) ? 1 : SPACING);
      chk("sw_ldcnt", ldcnt, 4'b0001);
      s = dicnt[4:0];
      chk("sw_tap", s, p);
    end
    wait_done(60, n);
    chk("sw_done_lat", n, SPACING);
    tick();
    chk("sw_ld_count", ld_total - ld0, 4);
    chk("sw_done_count", done_total - dn0, 1);
    chk("sw_dicnt_all", dicnt, 20'h04403);
    chk("sw_err", err, 0);

    // Readback stuck at 0 on ch1
    stuck_mask = 20'h003E0;
    dn0 = done_total;
    send(2'd1, 1'b0, 5'd9);
    wait_ld(10, n);
    chk("rb_ldcnt", ldcnt, 4'b0010);
    s = dicnt[9:5];
    chk("rb_dicnt", s, 9);
    wait_done(30, n);
    chk("rb_done", done, 1);
    chk("rb_err", err, VERIFY);
    tick();
    chk("rb_err_sticky", err, VERIFY);
    chk("rb_done_count", done_total - dn0, 1);
    stuck_mask = '0;
    send(2'd1, 1'b0, 5'd9);
    chk("rb_err_clear", err, 0);
    wait_done(40, n);
    chk("rb2_done", done, 1);
    chk("rb2_err", err, 0);
    tick();

    // Ready gating, stray command while busy, dly_rdy drop mid-operation
    dly_rdy = 1'b0;
    ld0 = ld_total; dn0 = done_total;
    send(2'd3, 1'b0, 5'd5);
    cmd_ch = 2'd0; cmd_sweep = 1'b0; cmd_tap = 5'd1; cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) tick();
    chk("rg_cmd_ready", cmd_ready, 0);
    chk("rg_busy", busy, 1);
    chk("rg_no_ld", ld_total - ld0, 0);
    cmd_valid = 1'b0;
    dly_rdy = 1'b1;
    wait_ld(10, n);
    chk("rg_ld_lat", n, 1);
    chk("rg_ldcnt", ldcnt, 4'b1000);
    dly_rdy = 1'b0;
    wait_done(30, n);
    chk("rg_done_lat", n, CHK_LAT + 1);
    tick();
    chk("rg_dicnt_all", dicnt, 20'h2C523);
    chk("rg_ld_count", ld_total - ld0, 1);
    chk("rg_done_count", done_total - dn0, 1);
    chk("rg_idle", busy, 0);
    dly_rdy = 1'b1;

    // Abort during DWELL at tap 2 of 0..5
    dn0 = done_total;
    send(2'd0, 1'b1, 5'd5);
    for (int p = 0; p < 3; p++) wait_ld(40, n);
    s = dicnt[4:0];
    chk("ab_tap2", s, 2);
    for (int i = 0; i < CHK_LAT + 3; i++) tick();
    chk("ab_busy_dwell", busy, 1);
    chk("ab_ldcnt_dwell", ldcnt, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_idle", busy, 0);
    chk("ab_cmd_ready", cmd_ready, 1);
    s = dicnt[4:0];
    chk("ab_dicnt", s, 2);
    ld0 = ld_total;
    for (int i = 0; i < 20; i++) tick();
    chk("ab_no_ld", ld_total - ld0, 0);
    chk("ab_no_done", done_total - dn0, 0);
    cmd_ch = 2'd1; cmd_sweep = 1'b0; cmd_tap = 5'd7;
    cmd_valid = 1'b1;
    abort = 1'b1;
    tick();
    cmd_valid = 1'b0;
    abort = 1'b0;
    chk("ab_accept_blocked", busy, 0);

    // Asynchronous reset mid-sweep
    send(2'd2, 1'b1, 5'd4);
    wait_ld(40, n);
    wait_ld(40, n);
    tick(); tick(); tick();
    #2 rst = 1'b1;
    #1;
    chk("ar_ldcnt", ldcnt, 0);
    chk("ar_dicnt", dicnt, 0);
    chk("ar_cur_tap", cur_tap, 0);
    chk("ar_done", done, 0);
    chk("ar_err", err, 0);
    chk("ar_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("ar_cmd_ready", cmd_ready, 1);

    // Full sweep ch3 end tap 31
    ld0 = ld_total; dn0 = done_total; er0 = err_cycles;
    send(2'd3, 1'b1, 5'd31);
    for (int p = 0; p < 32; p++) begin
      wait_ld(40, n);
      s = dicnt[19:15];
      chk("f31_tap", s, p);
    end
    wait_done(60, n);
    chk("f31_done", done, 1);
    chk("f31_cur_tap", cur_tap, 31);
    tick();
    chk("f31_ld_count", ld_total - ld0, 32);
    chk("f31_done_count", done_total - dn0, 1);
    chk("f31_dicnt_all", dicnt, 20'hF8000);
    chk("f31_err_cycles", err_cycles - er0, 0);
    chk("f31_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
